// File: rtl/read_burst_req_gen.sv
// ----------------------------------------------------------------------------
// read_burst_req_gen
//
// Per-frame AXI4 read-address generator for the VDMA read path. Starting from
// a frame base address it issues INCR read bursts, counts R beats to detect
// the end of each burst, and reports completion to the upstream length block
// (read_line_len_sum) with one-cycle burst_done / tail_done pulses. The
// upstream block answers with tail_leave / tail_len, which pick the length of
// the next burst.
//
// Ports
//   clock, rst_n          : clock, asynchronous active-low reset
//   enable, fsync         : frame enable, one-cycle frame start pulse
//   baseaddr              : frame base byte address (sampled on fsync)
//   fifo_space            : free beats in the downstream data FIFO
//   tail_leave, tail_len  : upstream length status (next burst is the tail)
//   burst_done, tail_done : completion pulses back to the upstream block
//   frame_busy            : frame in progress
//   rlast_err             : sticky misplaced/missing rlast flag
//   ar*                   : AXI read-address channel (arid/arsize/arburst const)
//   rvalid, rlast, rready : AXI read-data handshake (data routed elsewhere)
// ----------------------------------------------------------------------------
module read_burst_req_gen #(
  parameter int NOR_BURST_LEN = 200,
  parameter int LSIZE         = 9,
  parameter int AXI_DSIZE     = 256,
  parameter int ASIZE         = 32,
  parameter int IDSIZE        = 4,
  parameter int ID            = 0,
  parameter int SETTLE_CYC    = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fsync,
  input  logic [ASIZE-1:0]  baseaddr,
  input  logic [15:0]       fifo_space,
  input  logic              tail_leave,
  input  logic [LSIZE-1:0]  tail_len,
  output logic              burst_done,
  output logic              tail_done,
  output logic              frame_busy,
  output logic              rlast_err,
  output logic [IDSIZE-1:0] arid,
  output logic [ASIZE-1:0]  araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic              rvalid,
  input  logic              rlast,
  output logic              rready
);

  // Burst length register must hold both 256 (normal max) and any tail_len.
  localparam int LW     = (LSIZE > 9) ? LSIZE : 9;
  localparam int BSHIFT = $clog2(AXI_DSIZE / 8);
  localparam int CW     = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTLE    = 3'd1,
    S_WAIT_ROOM = 3'd2,
    S_ADDR      = 3'd3,
    S_DATA      = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [ASIZE-1:0] r_addr;
  logic [ASIZE-1:0] r_pend_addr;
  logic [LW-1:0]    r_len;
  logic [LW-1:0]    r_beat;
  logic             r_is_tail;
  logic             r_pend;
  logic             r_rlast_err;

  logic [LW-1:0]    w_len;
  logic             w_room;
  logic             w_beat;
  logic             w_last;
  logic [ASIZE-1:0] w_inc;
  logic             w_start;
  logic             w_reload;
  logic             w_latch;
  logic             w_set_pend;
  logic             w_advance;
  logic             w_burst_done;
  logic             w_tail_done;

  assign w_len  = tail_leave ? LW'(tail_len) : LW'(NOR_BURST_LEN);
  assign w_room = ({16'd0, fifo_space} >= 32'(w_len));
  assign w_beat = rvalid && (r_state == S_DATA);
  assign w_last = (r_beat == (r_len - LW'(1)));
  assign w_inc  = ASIZE'(r_len) << BSHIFT;

  // Next-state and control decode. w_start restarts the frame from baseaddr,
  // w_reload restarts it from the address captured by a deferred fsync.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_reload     = 1'b0;
    w_latch      = 1'b0;
    w_set_pend   = 1'b0;
    w_advance    = 1'b0;
    w_burst_done = 1'b0;
    w_tail_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fsync && enable) begin
          w_start      = 1'b1;
          w_next_state = S_SETTLE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (fsync) begin
          w_start      = 1'b1;
          w_next_state = S_SETTLE;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = S_WAIT_ROOM;
        end else begin
          w_next_state = S_SETTLE;
        end
      end
      S_WAIT_ROOM: begin
        if (fsync) begin
          w_start      = 1'b1;
          w_next_state = S_SETTLE;
        end else if (w_room) begin
          w_latch      = 1'b1;
          w_next_state = S_ADDR;
        end else begin
          w_next_state = S_WAIT_ROOM;
        end
      end
      // A started AXI transaction is never abandoned: fsync is only recorded.
      S_ADDR: begin
        w_set_pend = fsync;
        if (arready) begin
          w_next_state = S_DATA;
        end else begin
          w_next_state = S_ADDR;
        end
      end
      S_DATA: begin
        w_set_pend = fsync;
        if (w_beat && w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_DONE: begin
        if (fsync) begin
          w_start      = 1'b1;
          w_next_state = S_SETTLE;
        end else if (r_pend) begin
          w_reload     = 1'b1;
          w_next_state = S_SETTLE;
        end else begin
          w_advance = 1'b1;
          if (r_is_tail) begin
            w_tail_done  = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_burst_done = 1'b1;
            w_next_state = S_SETTLE;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: settle counter, address, burst length, beat count, fsync
  // deferral and the sticky rlast check.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_pend_addr <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_is_tail   <= 1'b0;
      r_pend      <= 1'b0;
      r_rlast_err <= 1'b0;
    end else begin
      // Counter restarts on every (re)entry into SETTLE.
      if ((r_state == S_SETTLE) && (w_next_state == S_SETTLE) && !w_start) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end

      if (w_start) begin
        r_addr <= baseaddr;
      end else if (w_reload) begin
        r_addr <= r_pend_addr;
      end else if (w_advance) begin
        r_addr <= r_addr + w_inc;
      end

      if (w_latch) begin
        r_len     <= w_len;
        r_is_tail <= tail_leave;
      end

      if (r_state == S_ADDR) begin
        r_beat <= '0;
      end else if (w_beat) begin
        r_beat <= r_beat + LW'(1);
      end

      if (w_start || w_reload) begin
        r_pend <= 1'b0;
      end else if (w_set_pend) begin
        r_pend <= 1'b1;
      end

      // The latest deferred fsync decides the next frame base.
      if (w_set_pend) begin
        r_pend_addr <= baseaddr;
      end

      // rlast must appear on the final counted beat and nowhere else.
      if (w_start || w_reload) begin
        r_rlast_err <= 1'b0;
      end else if (w_beat && (rlast != w_last)) begin
        r_rlast_err <= 1'b1;
      end
    end
  end

  assign arid       = IDSIZE'(ID);
  assign arsize     = 3'(BSHIFT);
  assign arburst    = 2'b01;
  assign arvalid    = (r_state == S_ADDR);
  assign araddr     = arvalid ? r_addr : '0;
  assign arlen      = arvalid ? 8'(r_len - LW'(1)) : 8'd0;
  assign rready     = (r_state == S_DATA);
  assign frame_busy = (r_state != S_IDLE);
  assign rlast_err  = r_rlast_err;
  assign burst_done = w_burst_done;
  assign tail_done  = w_tail_done;

endmodule

// File: tb/tb_read_burst_req_gen.sv
// ----------------------------------------------------------------------------
// tb_read_burst_req_gen
//
// Directed sequence plus randomized frames. The bench plays the roles of the
// upstream length block (remaining beats in the frame), the AXI slave
// (arready delay, randomly gapped R beats with optional rlast faults) and a
// transaction-level reference that lists the expected bursts of each frame.
// ----------------------------------------------------------------------------
module tb_read_burst_req_gen;

  localparam int NOR    = 200;
  localparam int SETTLE = 4;
  localparam int BYTES  = 32;

  logic        clock;
  logic        rst_n;
  logic        enable;
  logic        fsync;
  logic [31:0] baseaddr;
  logic [15:0] fifo_space;
  logic        tail_leave;
  logic [8:0]  tail_len;
  logic        burst_done;
  logic        tail_done;
  logic        frame_busy;
  logic        rlast_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic        rvalid;
  logic        rlast;
  logic        rready;

  read_burst_req_gen dut (
    .clock(clock), .rst_n(rst_n), .enable(enable), .fsync(fsync),
    .baseaddr(baseaddr), .fifo_space(fifo_space), .tail_leave(tail_leave),
    .tail_len(tail_len), .burst_done(burst_done), .tail_done(tail_done),
    .frame_busy(frame_busy), .rlast_err(rlast_err), .arid(arid),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rvalid(rvalid), .rlast(rlast),
    .rready(rready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          vectors;
  int          miscompares;
  int          cyc;
  int          remaining;
  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_len_q[$];
  int          exp_kind_q[$];
  int          r_q[$];
  int          r_idx;
  int          err_beat;
  logic        exp_err;
  int          ar_hold;
  int          ar_wait;
  int          rv_pct;
  bit          rand_mode;
  int          last_beat_cyc;
  int          last_done_cyc;
  int          fsync_cyc;
  int          fifo_cyc;
  bit          chk_first;
  bit          chk_fifo;
  int          arvalid_cnt;
  logic        prev_arvalid;
  logic [31:0] prev_araddr;
  logic [7:0]  prev_arlen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive environment inputs, sample and score, advance.
  task automatic tick();
    tail_leave = (remaining <= NOR);
    tail_len   = 9'(remaining);
    if (rand_mode) fifo_space = 16'($urandom_range(0, 300));
    if (arvalid) begin
      arready = (ar_wait >= ar_hold);
      ar_wait++;
    end else begin
      arready = 1'b0;
      ar_wait = 0;
    end
    if (r_q.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
      rvalid = 1'b1;
      rlast  = ((r_idx + 1) == r_q[0]) != ((r_idx + 1) == err_beat);
    end else begin
      rvalid = 1'b0;
      rlast  = 1'b0;
    end
    #1;
    chk("rlast_err", rlast_err, exp_err);
    if (fsync) exp_err = 1'b0;
    if (arvalid) arvalid_cnt++;
    if (arvalid && !prev_arvalid) begin
      if (chk_first) begin
        chk("fsync_to_arvalid", cyc - fsync_cyc, SETTLE + 2);
        chk_first = 1'b0;
      end
      if (chk_fifo) begin
        chk("room_to_arvalid", cyc - fifo_cyc, 1);
        chk_fifo = 1'b0;
      end
      if (last_done_cyc >= 0) begin
        chk("done_to_arvalid_gap", (cyc - last_done_cyc) >= (SETTLE + 2), 1);
        last_done_cyc = -1;
      end
    end
    if (arvalid && prev_arvalid) begin
      chk("araddr_stable", araddr, prev_araddr);
      chk("arlen_stable", arlen, prev_arlen);
    end
    if (arvalid && arready) begin
      chk("r_channel_drained", r_q.size(), 0);
      chk("arsize", arsize, 5);
      chk("arburst", arburst, 1);
      chk("arid", arid, 0);
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_ar", 1, 0);
      end else begin
        chk("araddr", araddr, exp_addr_q.pop_front());
        chk("arlen", arlen, exp_len_q.pop_front());
      end
      r_q.push_back(int'(arlen) + 1);
      r_idx = 0;
      if (rand_mode) ar_hold = $urandom_range(0, 3);
    end
    if (rvalid && rready) begin
      r_idx++;
      if (rlast != (r_idx == r_q[0])) exp_err = 1'b1;
      if (r_idx == r_q[0]) begin
        void'(r_q.pop_front());
        r_idx         = 0;
        last_beat_cyc = cyc;
        err_beat      = 0;
      end
    end
    if (burst_done || tail_done) begin
      chk("done_onehot", burst_done && tail_done, 0);
      chk("done_latency", cyc - last_beat_cyc, 1);
      if (exp_kind_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        chk("done_kind", tail_done, exp_kind_q.pop_front());
      end
      if (burst_done) begin
        remaining     = remaining - NOR;
        last_done_cyc = cyc;
      end else begin
        remaining     = 0;
        last_done_cyc = -1;
      end
    end
    prev_arvalid = arvalid;
    prev_araddr  = araddr;
    prev_arlen   = arlen;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Expected bursts of an n-beat frame, then one fsync cycle.
  task automatic start_frame(input logic [31:0] base, input int n);
    logic [31:0] a;
    int          rem;
    a   = base;
    rem = n;
    exp_addr_q.delete();
    exp_len_q.delete();
    exp_kind_q.delete();
    while (rem > 0) begin
      exp_addr_q.push_back(a);
      if (rem <= NOR) begin
        exp_len_q.push_back(8'(rem - 1));
        exp_kind_q.push_back(1);
        rem = 0;
      end else begin
        exp_len_q.push_back(8'(NOR - 1));
        exp_kind_q.push_back(0);
        rem = rem - NOR;
        a   = a + 32'(NOR * BYTES);
      end
    end
    remaining     = n;
    baseaddr      = base;
    fsync         = 1'b1;
    enable        = 1'b1;
    fsync_cyc     = cyc;
    last_done_cyc = -1;
    tick();
    fsync    = 1'b0;
    baseaddr = $urandom();
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (frame_busy && k < budget) begin
      tick();
      k++;
    end
    chk("frame_end_busy", frame_busy, 0);
    chk("ar_left", exp_addr_q.size(), 0);
    chk("done_left", exp_kind_q.size(), 0);
  endtask

  task automatic wait_beats(input int n, input int ar_left, input int budget);
    int k;
    k = 0;
    while (!(r_q.size() > 0 && r_idx >= n && exp_addr_q.size() == ar_left) && k < budget) begin
      tick();
      k++;
    end
    chk("beat_wait", (r_q.size() > 0) && (r_idx >= n), 1);
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; remaining = 0;
    r_idx = 0; err_beat = 0; exp_err = 1'b0; ar_hold = 0; ar_wait = 0;
    rv_pct = 100; rand_mode = 1'b0; last_beat_cyc = -10; last_done_cyc = -1;
    fsync_cyc = 0; fifo_cyc = 0; chk_first = 1'b0; chk_fifo = 1'b0;
    arvalid_cnt = 0; prev_arvalid = 1'b0; prev_araddr = '0; prev_arlen = '0;
    rst_n = 1'b0; enable = 1'b0; fsync = 1'b0; baseaddr = '0;
    fifo_space = 16'd1000; tail_leave = 1'b0; tail_len = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_arvalid", arvalid, 0);
    chk("reset_rready", rready, 0);
    chk("reset_busy", frame_busy, 0);
    chk("reset_done", {burst_done, tail_done}, 0);
    chk("reset_rlast_err", rlast_err, 0);
    chk("reset_araddr", araddr, 0);
    chk("reset_arlen", arlen, 0);
    chk("reset_arsize", arsize, 5);
    chk("reset_arburst", arburst, 1);
    rst_n = 1'b1;
    tick();
    // fsync with enable low is ignored.
    enable = 1'b0; fsync = 1'b1; tick(); fsync = 1'b0; tick();
    chk("fsync_disabled_busy", frame_busy, 0);

    // 450-beat frame: bursts at 0x1000, 0x2900, 0x4200.
    chk_first = 1'b1;
    start_frame(32'h0000_1000, 450);
    chk("busy_after_fsync", frame_busy, 1);
    wait_idle(2000);

    // Exactly two full bursts: last one is a 200-beat tail.
    chk_first = 1'b1;
    start_frame(32'h0002_0000, 400);
    wait_idle(2000);

    // arready held off for 7 cycles.
    ar_hold = 7; rv_pct = 60; arvalid_cnt = 0;
    start_frame(32'h0003_0040, 200);
    wait_idle(2000);
    chk("arvalid_cycles_hold7", arvalid_cnt, 8);
    ar_hold = 0; rv_pct = 100;

    // Not enough FIFO room for a 200-beat burst.
    fifo_space = 16'd100; arvalid_cnt = 0;
    start_frame(32'h0004_0000, 450);
    repeat (20) tick();
    chk("no_arvalid_without_room", arvalid_cnt, 0);
    fifo_space = 16'd200; fifo_cyc = cyc; chk_fifo = 1'b1;
    wait_idle(3000);
    fifo_space = 16'd1000;

    // fsync at beat 50: burst completes, no pulse, restart at new base.
    rv_pct = 80;
    start_frame(32'h0005_0000, 450);
    wait_beats(50, 2, 500);
    start_frame(32'h0006_1000, 450);
    wait_idle(3000);

    // Early rlast on beat 100: sticky error, burst still ends at beat 200.
    rv_pct = 100; err_beat = 100;
    start_frame(32'h0007_0000, 450);
    wait_idle(2000);
    chk("rlast_err_sticky", rlast_err, 1);
    start_frame(32'h0008_0000, 300);
    chk("rlast_err_cleared", rlast_err, 0);
    // Missing rlast on the final beat of the first burst.
    err_beat = 200;
    wait_beats(10, 0, 1000);
    chk("rlast_missing_err", rlast_err, 1);
    chk("mid_data_rready", rready, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_busy", frame_busy, 0);
    chk("rst_rlast_err", rlast_err, 0);
    chk("rst_done", {burst_done, tail_done}, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_arsize", arsize, 5);
    chk("rst_arburst", arburst, 1);
    chk("rst_arid", arid, 0);
    r_q.delete(); exp_addr_q.delete(); exp_len_q.delete(); exp_kind_q.delete();
    remaining = 0; r_idx = 0; exp_err = 1'b0; err_beat = 0; last_done_cyc = -1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Randomized frames.
    rand_mode = 1'b1;
    for (int f = 0; f < 6; f++) begin
      rv_pct = $urandom_range(30, 100);
      start_frame($urandom(), $urandom_range(1, 700));
      wait_idle(6000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
